// File: rtl/portao_pkg.sv
// Shared definitions for the gate controller: state codes and default timing.
package portao_pkg;

    typedef enum logic [2:0] {
        ST_CLOSED  = 3'd0,
        ST_OPENING = 3'd1,
        ST_OPEN    = 3'd2,
        ST_CLOSING = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    localparam int DEFAULT_HOLD_CYCLES = 8;
    localparam int DEFAULT_MOVE_MAX    = 16;
    localparam int DEFAULT_CNT_W       = 8;

endpackage

// File: rtl/portao_req.sv
// Gate-request equation: v = a | (b & c) | (~(a | b) & d).
module portao_req
    import portao_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic v
);

    // Pure combinational request decode
    always_comb begin
        v = a | (b & c) | (~(a | b) & d);
    end

endmodule

// File: rtl/portao_ctrl.sv
// Motorised gate sequencer: five-state Moore FSM with auto-close hold timer,
// obstacle reversal, travel timeout and limit-switch conflict detection.
module portao_ctrl
    import portao_pkg::*;
#(
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter int MOVE_MAX    = DEFAULT_MOVE_MAX,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       lim_open,
    input  logic       lim_closed,
    input  logic       obstacle,
    output logic       motor_open,
    output logic       motor_close,
    output logic       door_open,
    output logic       fault,
    output logic [2:0] state
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_MAX - 1);

    logic             v;
    state_t           cur_state;
    state_t           nxt_state;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] nxt_hold;
    logic [CNT_W-1:0] travel_cnt;
    logic [CNT_W-1:0] nxt_travel;

    portao_req u_req (
        .a (a),
        .b (b),
        .c (c),
        .d (d),
        .v (v)
    );

    assign state = cur_state;

    // Next-state and counter update rules; a limit-switch conflict overrides everything
    always_comb begin
        nxt_state  = cur_state;
        nxt_hold   = hold_cnt;
        nxt_travel = travel_cnt;
        if (cur_state != ST_FAULT && lim_open && lim_closed) begin
            nxt_state = ST_FAULT;
        end else begin
            case (cur_state)
                ST_CLOSED: begin
                    if (v) begin
                        nxt_state  = ST_OPENING;
                        nxt_travel = '0;
                    end
                end
                ST_OPENING: begin
                    if (lim_open) begin
                        nxt_state = ST_OPEN;
                        nxt_hold  = HOLD_LAST;
                    end else if (travel_cnt == MOVE_LAST) begin
                        nxt_state = ST_FAULT;
                    end else begin
                        nxt_travel = travel_cnt + 1'b1;
                    end
                end
                ST_OPEN: begin
                    if (v) begin
                        nxt_hold = HOLD_LAST;
                    end else if (hold_cnt == '0) begin
                        nxt_state  = ST_CLOSING;
                        nxt_travel = '0;
                    end else begin
                        nxt_hold = hold_cnt - 1'b1;
                    end
                end
                ST_CLOSING: begin
                    if (obstacle || v) begin
                        nxt_state  = ST_OPENING;
                        nxt_travel = '0;
                    end else if (lim_closed) begin
                        nxt_state = ST_CLOSED;
                    end else if (travel_cnt == MOVE_LAST) begin
                        nxt_state = ST_FAULT;
                    end else begin
                        nxt_travel = travel_cnt + 1'b1;
                    end
                end
                ST_FAULT: begin
                    nxt_state = ST_FAULT;
                end
                default: begin
                    nxt_state = ST_CLOSED;
                end
            endcase
        end
    end

    // State, counters and Moore outputs registered together so outputs track the state edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state   <= ST_CLOSED;
            hold_cnt    <= '0;
            travel_cnt  <= '0;
            motor_open  <= 1'b0;
            motor_close <= 1'b0;
            door_open   <= 1'b0;
            fault       <= 1'b0;
        end else begin
            cur_state   <= nxt_state;
            hold_cnt    <= nxt_hold;
            travel_cnt  <= nxt_travel;
            motor_open  <= (nxt_state == ST_OPENING);
            motor_close <= (nxt_state == ST_CLOSING);
            door_open   <= (nxt_state == ST_OPEN);
            fault       <= (nxt_state == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_portao_ctrl.sv
// Self-checking bench for portao_ctrl: directed scenarios followed by random
// stimulus, all compared against a cycle-count reference model of the gate.
module tb_portao_ctrl;

    localparam int HOLD = 4;
    localparam int MOVE = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a, b, c, d;
    logic       lim_open, lim_closed, obstacle;
    logic       motor_open, motor_close, door_open, fault;
    logic [2:0] state;

    int checks   = 0;
    int failures = 0;

    // Reference model: state code plus "cycles spent" counters
    int m_state;
    int m_age;
    int m_idle;

    portao_ctrl #(
        .HOLD_CYCLES (HOLD),
        .MOVE_MAX    (MOVE),
        .CNT_W       (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a),
        .b           (b),
        .c           (c),
        .d           (d),
        .lim_open    (lim_open),
        .lim_closed  (lim_closed),
        .obstacle    (obstacle),
        .motor_open  (motor_open),
        .motor_close (motor_close),
        .door_open   (door_open),
        .fault       (fault),
        .state       (state)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_state = 0;
        m_age   = 0;
        m_idle  = 0;
    endtask

    // Gate behaviour written from the rules: request truth, then per-state time accounting
    task automatic modelStep();
        bit req;
        req = (a === 1'b1) || (b === 1'b1 && c === 1'b1) || (a === 1'b0 && b === 1'b0 && d === 1'b1);
        if (m_state != 4 && lim_open && lim_closed) begin
            m_state = 4;
        end else if (m_state == 0) begin
            if (req) begin m_state = 1; m_age = 1; end
        end else if (m_state == 1) begin
            if (lim_open) begin m_state = 2; m_idle = 0; end
            else if (m_age == MOVE) m_state = 4;
            else m_age++;
        end else if (m_state == 2) begin
            if (req) m_idle = 0;
            else begin
                m_idle++;
                if (m_idle == HOLD) begin m_state = 3; m_age = 1; end
            end
        end else if (m_state == 3) begin
            if (obstacle || req) begin m_state = 1; m_age = 1; end
            else if (lim_closed) m_state = 0;
            else if (m_age == MOVE) m_state = 4;
            else m_age++;
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ":state"}, 32'(state), 32'(m_state));
        checkOutput({tag, ":motor_open"}, 32'(motor_open), 32'(m_state == 1));
        checkOutput({tag, ":motor_close"}, 32'(motor_close), 32'(m_state == 3));
        checkOutput({tag, ":door_open"}, 32'(door_open), 32'(m_state == 2));
        checkOutput({tag, ":fault"}, 32'(fault), 32'(m_state == 4));
    endtask

    // Drive one cycle of inputs, clock it, advance the model and compare
    task automatic applyStimulus(input logic ia, input logic ib, input logic ic, input logic id,
                                 input logic lo, input logic lc, input logic ob, input string tag);
        a = ia; b = ib; c = ic; d = id;
        lim_open = lo; lim_closed = lc; obstacle = ob;
        @(posedge clk);
        modelStep();
        #1;
        checkAll(tag);
    endtask

    task automatic doReset(input string tag);
        @(negedge clk);
        a = 0; b = 0; c = 0; d = 0; lim_open = 0; lim_closed = 0; obstacle = 0;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkAll(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        a = 0; b = 0; c = 0; d = 0; lim_open = 0; lim_closed = 0; obstacle = 0;
        modelReset();

        // Reset, open, hold, close
        doReset("reset");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, "req_a");
        checkOutput("a_opening_state", 32'(state), 32'd1);
        checkOutput("a_opening_motor", 32'(motor_open), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, "opening1");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, "opening2");
        applyStimulus(0, 0, 0, 0, 1, 0, 0, "lim_open");
        checkOutput("open_state", 32'(state), 32'd2);
        checkOutput("open_door", 32'(door_open), 32'd1);
        checkOutput("open_motor_off", 32'(motor_open), 32'd0);
        for (int i = 0; i < HOLD; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, "hold");
            if (i < HOLD - 1) checkOutput("hold_stays_open", 32'(state), 32'd2);
        end
        checkOutput("autoclose_state", 32'(state), 32'd3);
        checkOutput("autoclose_motor", 32'(motor_close), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, "lim_closed");
        checkOutput("closed_state", 32'(state), 32'd0);

        // Request equation corners
        applyStimulus(0, 1, 0, 1, 0, 0, 0, "req_b_d");
        checkOutput("req_bd_no_move", 32'(state), 32'd0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, "req_d");
        checkOutput("req_d_opening", 32'(state), 32'd1);
        doReset("reset2");
        applyStimulus(0, 1, 1, 0, 0, 0, 0, "req_bc");
        checkOutput("req_bc_opening", 32'(state), 32'd1);

        // Obstacle with lim_closed in the second closing cycle, then timeout
        applyStimulus(0, 0, 0, 0, 1, 0, 0, "to_open");
        for (int i = 0; i < HOLD; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, "hold2");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, "closing1");
        applyStimulus(0, 0, 0, 0, 0, 1, 1, "obstacle");
        checkOutput("reverse_state", 32'(state), 32'd1);
        checkOutput("reverse_close_off", 32'(motor_close), 32'd0);
        for (int i = 0; i < MOVE - 1; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, "travel");
        checkOutput("travel_not_yet_fault", 32'(state), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, "timeout");
        checkOutput("timeout_fault", 32'(fault), 32'd1);
        checkOutput("timeout_motor", 32'(motor_open), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, "fault_sticky");
        checkOutput("fault_absorbing", 32'(state), 32'd4);

        // Limit conflict while closed
        doReset("reset3");
        applyStimulus(0, 0, 0, 0, 1, 1, 0, "conflict");
        checkOutput("conflict_fault", 32'(state), 32'd4);

        // Asynchronous reset mid-closing
        doReset("reset4");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, "go");
        applyStimulus(0, 0, 0, 0, 1, 0, 0, "opened");
        for (int i = 0; i < HOLD; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, "hold3");
        checkOutput("pre_async_closing", 32'(motor_close), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_motor_close", 32'(motor_close), 32'd0);
        checkOutput("async_state", 32'(state), 32'd0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic ra, rb, rc, rd, rlo, rlc, rob;
            if ($urandom_range(99) < 1 || (m_state == 4 && $urandom_range(9) == 0)) begin
                doReset("rnd_reset");
            end else begin
                ra  = ($urandom_range(99) < 10);
                rb  = ($urandom_range(99) < 30);
                rc  = ($urandom_range(99) < 30);
                rd  = ($urandom_range(99) < 30);
                rlo = ($urandom_range(99) < ((m_state == 1) ? 20 : 3));
                rlc = ($urandom_range(99) < ((m_state == 3) ? 20 : 3));
                rob = ($urandom_range(99) < 5);
                applyStimulus(ra, rb, rc, rd, rlo, rlc, rob, "rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
